// File: rtl/multicore_system_dispatch_pkg.sv
// ============================================================================
// multicore_system_dispatch_pkg : register map, CONTROL bits, dispatch modes
// Revision: 1.0
// ============================================================================
`default_nettype none

package multicore_system_dispatch_pkg;

  localparam logic [2:0] ADDR_STATUS     = 3'd0;
  localparam logic [2:0] ADDR_CONTROL    = 3'd1;
  localparam logic [2:0] ADDR_MASK       = 3'd2;
  localparam logic [2:0] ADDR_RR_PTR     = 3'd3;
  localparam logic [2:0] ADDR_TICK_COUNT = 3'd4;
  localparam logic [2:0] ADDR_OVERFLOW   = 3'd5;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_MODE_BIT   = 1;

  typedef enum logic {
    MODE_BROADCAST   = 1'b0,
    MODE_ROUND_ROBIN = 1'b1
  } mode_e;

endpackage

`default_nettype wire

// File: rtl/multicore_system_rr_pick.sv
// ============================================================================
// multicore_system_rr_pick : first masked core at or above rr_ptr, with wrap
// Revision: 1.0
// ============================================================================
`default_nettype none

module multicore_system_rr_pick #(
  parameter int NUM_CORES = 4,
  parameter int PTR_W     = $clog2(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] mask,
  input  logic [PTR_W-1:0]     rr_ptr,
  output logic [PTR_W-1:0]     target,
  output logic                 valid
);

  int unsigned       idx;
  logic [PTR_W-1:0]  idx_t;

  // Scan offsets from farthest to nearest so the nearest masked core wins.
  always_comb begin
    target = '0;
    valid  = |mask;
    idx    = 0;
    idx_t  = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      idx   = (32'(rr_ptr) + 32'(k)) % 32'(NUM_CORES);
      idx_t = idx[PTR_W-1:0];
      if (mask[idx_t]) begin
        target = idx_t;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/multicore_system_tick_dispatcher.sv
// ============================================================================
// multicore_system_tick_dispatcher : timer irq -> per-core tick interrupts
// Optional TICK_COUNT register: MULTICORE_SYSTEM_TICK_DISPATCH_COUNT_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module multicore_system_tick_dispatcher
  import multicore_system_dispatch_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int PEND_W    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           address,
  input  logic                 chipselect,
  input  logic                 write_n,
  input  logic [15:0]          writedata,
  output logic [15:0]          readdata,
  input  logic                 timer_irq,
  output logic [NUM_CORES-1:0] core_irq
);

  localparam int              PTR_W    = $clog2(NUM_CORES);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic                 timer_irq_d;
  logic [1:0]           control;
  logic [NUM_CORES-1:0] mask;
  logic [NUM_CORES-1:0] overflow;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PEND_W-1:0]    pending     [NUM_CORES];
  logic [PEND_W-1:0]    pending_nxt [NUM_CORES];
  logic [NUM_CORES-1:0] pend_nz, pend_nz_nxt, inc, ack, ov_set, ov_clr;
  logic [PTR_W-1:0]     rr_target;
  logic                 rr_valid;
  logic                 wr, tick, enable, dispatch;
  mode_e                mode;
  logic [15:0]          rd_nxt;
  logic                 unused_bits;

  assign wr          = chipselect & ~write_n;
  assign tick        = timer_irq & ~timer_irq_d;
  assign enable      = control[CTRL_ENABLE_BIT];
  assign mode        = mode_e'(control[CTRL_MODE_BIT]);
  assign dispatch    = tick & enable & (|mask);
  assign ack         = (wr && address == ADDR_STATUS)   ? writedata[NUM_CORES-1:0] : '0;
  assign ov_clr      = (wr && address == ADDR_OVERFLOW) ? writedata[NUM_CORES-1:0] : '0;
  assign unused_bits = ^writedata[15:NUM_CORES];

  multicore_system_rr_pick #(
    .NUM_CORES (NUM_CORES),
    .PTR_W     (PTR_W)
  ) u_rr_pick (
    .mask   (mask),
    .rr_ptr (rr_ptr),
    .target (rr_target),
    .valid  (rr_valid)
  );

  // An ack only cancels an increment when it would actually have decremented.
  always_comb begin
    inc         = '0;
    ov_set      = '0;
    pend_nz     = '0;
    pend_nz_nxt = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      pending_nxt[i] = pending[i];
      pend_nz[i]     = (pending[i] != '0);
      if (mode == MODE_BROADCAST) begin
        inc[i] = dispatch & mask[i];
      end else begin
        inc[i] = dispatch & rr_valid & (rr_target == PTR_W'(i));
      end
      if (inc[i] && !(ack[i] && pend_nz[i])) begin
        if (pending[i] == PEND_MAX) begin
          ov_set[i] = 1'b1;
        end else begin
          pending_nxt[i] = pending[i] + 1'b1;
        end
      end else if (!inc[i] && ack[i] && pend_nz[i]) begin
        pending_nxt[i] = pending[i] - 1'b1;
      end
      pend_nz_nxt[i] = (pending_nxt[i] != '0);
    end
  end

`ifdef MULTICORE_SYSTEM_TICK_DISPATCH_COUNT_EN
  logic [15:0] tick_count;

  // A clear landing on a dispatch cycle still counts that dispatch.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_count <= '0;
    end else if (dispatch) begin
      tick_count <= (wr && address == ADDR_TICK_COUNT) ? 16'd1 : tick_count + 16'd1;
    end else if (wr && address == ADDR_TICK_COUNT) begin
      tick_count <= '0;
    end
  end
`endif

  always_comb begin
    rd_nxt = '0;
    case (address)
      ADDR_STATUS:     rd_nxt[NUM_CORES-1:0] = pend_nz;
      ADDR_CONTROL:    rd_nxt[1:0]           = control;
      ADDR_MASK:       rd_nxt[NUM_CORES-1:0] = mask;
      ADDR_RR_PTR:     rd_nxt[PTR_W-1:0]     = rr_ptr;
`ifdef MULTICORE_SYSTEM_TICK_DISPATCH_COUNT_EN
      ADDR_TICK_COUNT: rd_nxt                = tick_count;
`endif
      ADDR_OVERFLOW:   rd_nxt[NUM_CORES-1:0] = overflow;
      default:         rd_nxt                = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_irq_d <= 1'b0;
      control     <= '0;
      mask        <= '1;
      rr_ptr      <= '0;
      overflow    <= '0;
      core_irq    <= '0;
      readdata    <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        pending[i] <= '0;
      end
    end else begin
      timer_irq_d <= timer_irq;
      readdata    <= rd_nxt;
      core_irq    <= pend_nz_nxt;
      overflow    <= (overflow & ~ov_clr) | ov_set;
      for (int i = 0; i < NUM_CORES; i++) begin
        pending[i] <= pending_nxt[i];
      end
      if (wr && address == ADDR_CONTROL) begin
        control <= writedata[1:0];
      end
      if (wr && address == ADDR_MASK) begin
        mask <= writedata[NUM_CORES-1:0];
      end
      if (dispatch && mode == MODE_ROUND_ROBIN) begin
        rr_ptr <= (rr_target == PTR_W'(NUM_CORES - 1)) ? '0 : rr_target + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicore_system_tick_dispatcher.sv
// ============================================================================
// tb_multicore_system_tick_dispatcher : directed self-checking bench
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multicore_system_tick_dispatcher;

`ifdef MULTICORE_SYSTEM_TICK_DISPATCH_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        timer_irq;
  logic [3:0]  core_irq;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  multicore_system_tick_dispatcher #(
    .NUM_CORES (4),
    .PEND_W    (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .timer_irq  (timer_irq),
    .core_irq   (core_irq)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
  endtask

  function automatic logic [15:0] tc(input int v);
    return CNT_EN ? 16'(v) : 16'h0000;
  endfunction

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic pulse(input int hold);
    @(negedge clk);
    timer_irq = 1'b1;
    repeat (hold) @(negedge clk);
    timer_irq = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] d;
    logic [15:0] rst_exp [6];
    rst_exp = '{16'h0000, 16'h0000, 16'h000F, 16'h0000, 16'h0000, 16'h0000};

    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; timer_irq = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_readdata", readdata, 16'h0000);
    check("rst_core_irq", {12'h000, core_irq}, 16'h0000);
    reset = 1'b0;

    // 1: reset register values
    for (int a = 0; a < 6; a++) begin
      rd(3'(a), d);
      check($sformatf("rst_reg%0d", a), d, rst_exp[a]);
    end

    // 2: broadcast, held level is one event
    wr(3'd1, 16'h0001);
    pulse(10);
    check("bc_irq", {12'h000, core_irq}, 16'h000F);
    rd(3'd0, d); check("bc_status", d, 16'h000F);
    rd(3'd4, d); check("bc_tick_count", d, tc(1));
    wr(3'd0, 16'h0005);
    check("bc_ack5", {12'h000, core_irq}, 16'h000A);
    wr(3'd0, 16'h000A);
    check("bc_ackA", {12'h000, core_irq}, 16'h0000);

    // 3: round-robin over cores 1 and 3
    wr(3'd2, 16'h000A);
    wr(3'd1, 16'h0003);
    repeat (4) pulse(1);
    check("rr_irq", {12'h000, core_irq}, 16'h000A);
    rd(3'd3, d); check("rr_ptr0", d, 16'h0000);
    wr(3'd0, 16'h000A);
    check("rr_ack1", {12'h000, core_irq}, 16'h000A);
    wr(3'd0, 16'h000A);
    check("rr_ack2", {12'h000, core_irq}, 16'h0000);
    rd(3'd4, d); check("rr_tick_count", d, tc(5));

    // 4: saturation and overflow on core 0
    wr(3'd2, 16'h0001);
    repeat (16) pulse(1);
    check("sat_irq", {12'h000, core_irq}, 16'h0001);
    rd(3'd5, d); check("sat_overflow", d, 16'h0001);
    rd(3'd3, d); check("sat_rr_ptr", d, 16'h0001);
    wr(3'd5, 16'h0001);
    rd(3'd5, d); check("ovf_cleared", d, 16'h0000);
    check("ovf_irq_kept", {12'h000, core_irq}, 16'h0001);

    // 5: ack and tick in the same cycle at max
    @(negedge clk);
    timer_irq = 1'b1; address = 3'd0; chipselect = 1'b1; write_n = 1'b0; writedata = 16'h0001;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; timer_irq = 1'b0;
    rd(3'd5, d); check("same_cyc_overflow", d, 16'h0000);
    repeat (14) wr(3'd0, 16'h0001);
    check("pend15_after14", {12'h000, core_irq}, 16'h0001);
    wr(3'd0, 16'h0001);
    check("pend15_after15", {12'h000, core_irq}, 16'h0000);
    rd(3'd4, d); check("same_cyc_tick_count", d, tc(22));

    // 6: disabled dispatch drops events
    wr(3'd1, 16'h0000);
    repeat (3) pulse(1);
    check("dis_irq", {12'h000, core_irq}, 16'h0000);
    rd(3'd4, d); check("dis_tick_count", d, tc(22));
    rd(3'd3, d); check("dis_rr_ptr", d, 16'h0001);

    // clear counter, then mask does not gate existing pending
    wr(3'd4, 16'h0000);
    rd(3'd4, d); check("tc_cleared", d, 16'h0000);
    wr(3'd1, 16'h0001);
    wr(3'd2, 16'h000F);
    pulse(1);
    wr(3'd2, 16'h0000);
    check("mask_no_gate", {12'h000, core_irq}, 16'h000F);
    pulse(1);
    rd(3'd4, d); check("mask0_drop_count", d, tc(1));
    wr(3'd0, 16'h000F);
    check("mask0_ack", {12'h000, core_irq}, 16'h0000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
